// File: rtl/ss_pkg.sv
// Shared definitions for the seven-segment display arbiter: digit codes, FSM
// state encoding and the leading-zero blanking helper.
package ss_pkg;

  localparam logic [3:0] SS_BLANK = 4'hF;
  localparam logic [3:0] SS_DASH  = 4'hA;
  localparam logic [3:0] SS_U     = 4'hB;

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StShare
  } ss_state_e;

  // Zero digits above the first nonzero one turn blank; digit 0 always shows,
  // and any nonzero nibble (numeric or symbol) ends the scan.
  function automatic logic [31:0] lz_blank(logic [31:0] w);
    logic [31:0] r;
    logic        scan;
    r    = w;
    scan = 1'b1;
    for (int d = 7; d >= 1; d--) begin
      if (scan && (w[4*d +: 4] == 4'h0)) begin
        r[4*d +: 4] = SS_BLANK;
      end else begin
        scan = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ss_rr_pick.sv
// Combinational round-robin picker: first set request at or after start_i,
// wrapping modulo N, ignoring masked requesters.
module ss_rr_pick #(
  parameter int unsigned N    = 3,
  parameter int unsigned IdxW = 2
) (
  input  logic [N-1:0]    req_i,
  input  logic [N-1:0]    mask_i,
  input  logic [IdxW-1:0] start_i,
  output logic [N-1:0]    winner_o,
  output logic            valid_o
);

  logic [N-1:0]   cand;
  logic [2*N-1:0] dbl;
  logic [2*N-1:0] rot;
  logic [2*N-1:0] pick;

  assign cand = req_i & ~mask_i;
  assign dbl  = {cand, cand};
  assign rot  = dbl >> start_i;

  // Bit k of rot is requester (start_i + k) mod N; the winner's one-hot is
  // rebuilt by shifting into a double-width vector and folding the halves.
  always_comb begin
    valid_o = 1'b0;
    pick    = '0;
    for (int k = 0; k < N; k++) begin
      if (!valid_o && rot[k]) begin
        valid_o = 1'b1;
        pick    = {{(2*N-1){1'b0}}, 1'b1} << start_i;
        pick    = pick << k;
      end
    end
    winner_o = pick[N-1:0] | pick[2*N-1:N];
  end

endmodule

// File: rtl/ss_display_arbiter.sv
// Round-robin owner selection for the shared 8-digit display with a minimum
// hold time per owner; registers the owner's BCD word and DP for the driver.
module ss_display_arbiter
  import ss_pkg::*;
#(
  parameter int unsigned N           = 3,
  parameter int unsigned HOLD_CYCLES = 1_000_000,
  parameter int unsigned LZ_BLANK    = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [32*N-1:0] data_in,
  input  logic [N-1:0]    dp_in,
  output logic [N-1:0]    grant,
  output logic            owner_valid,
  output logic [31:0]     data_BCD,
  output logic            DP
);

  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CntW = $clog2(HOLD_CYCLES + 1);

  ss_state_e       state_q, state_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [CntW-1:0] hold_cnt_q, hold_cnt_d;
  logic [N-1:0]    grant_q, grant_d;
  logic            valid_q, valid_d;
  logic [31:0]     data_q, data_d;
  logic            dp_q, dp_d;

  logic [N-1:0]    owner_oh;
  logic [N-1:0]    mask;
  logic [IdxW-1:0] start;
  logic [N-1:0]    win_oh;
  logic            win_valid;
  logic [IdxW-1:0] win_idx;
  logic            owner_req;
  logic            do_switch;
  logic [31:0]     sel_word;
  logic            sel_dp;

  always_comb begin
    owner_oh = '0;
    for (int i = 0; i < N; i++) begin
      owner_oh[i] = (owner_q == IdxW'(i));
    end
  end

  // owner_q doubles as last_owner while idle, so the search always starts
  // just past whoever held the display most recently.
  assign start     = (owner_q == IdxW'(N - 1)) ? '0 : owner_q + 1'b1;
  assign mask      = (state_q == StIdle) ? '0 : owner_oh;
  assign owner_req = |(req & owner_oh);

  ss_rr_pick #(
    .N    (N),
    .IdxW (IdxW)
  ) u_rr_pick (
    .req_i    (req),
    .mask_i   (mask),
    .start_i  (start),
    .winner_o (win_oh),
    .valid_o  (win_valid)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (win_oh[i]) win_idx = IdxW'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    hold_cnt_d = hold_cnt_q;
    do_switch  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (win_valid) do_switch = 1'b1;
      end
      StHold: begin
        if (!owner_req) begin
          if (win_valid) do_switch = 1'b1;
          else           state_d   = StIdle;
        end else if (hold_cnt_q == '0) begin
          // Hold expired: hand over at once if contended so the owner gets
          // exactly HOLD_CYCLES cycles, otherwise keep it in SHARE.
          if (win_valid) do_switch = 1'b1;
          else           state_d   = StShare;
        end else begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end
      end
      StShare: begin
        if (win_valid)       do_switch = 1'b1;
        else if (!owner_req) state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (do_switch) begin
      state_d    = StHold;
      owner_d    = win_idx;
      hold_cnt_d = CntW'(HOLD_CYCLES - 1);
    end
  end

  always_comb begin
    sel_word = '0;
    sel_dp   = 1'b0;
    grant_d  = '0;
    for (int i = 0; i < N; i++) begin
      if (owner_d == IdxW'(i)) begin
        sel_word   = data_in[32*i +: 32];
        sel_dp     = dp_in[i];
        grant_d[i] = 1'b1;
      end
    end
    valid_d = (state_d != StIdle);
    if (!valid_d) begin
      grant_d = '0;
      data_d  = {8{SS_BLANK}};
      dp_d    = 1'b0;
    end else begin
      data_d = (LZ_BLANK != 0) ? lz_blank(sel_word) : sel_word;
      dp_d   = sel_dp;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      owner_q    <= IdxW'(N - 1);
      hold_cnt_q <= '0;
      grant_q    <= '0;
      valid_q    <= 1'b0;
      data_q     <= {8{SS_BLANK}};
      dp_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      hold_cnt_q <= hold_cnt_d;
      grant_q    <= grant_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      dp_q       <= dp_d;
    end
  end

  assign grant       = grant_q;
  assign owner_valid = valid_q;
  assign data_BCD    = data_q;
  assign DP          = dp_q;

endmodule

// File: tb/tb_ss_display_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// against an ownership-level reference model.
module tb_ss_display_arbiter;

  localparam int N    = 3;
  localparam int HOLD = 4;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [31:0]     din [N];
  logic [32*N-1:0] data_in;
  logic [N-1:0]    dp_in;
  logic [N-1:0]    grant;
  logic            owner_valid;
  logic [31:0]     data_bcd;
  logic            dp;

  int n_checks;
  int n_fail;

  // Reference model: who owns the display and for how many cycles so far.
  int m_owner;
  int m_last;
  int m_held;

  always_comb begin
    for (int i = 0; i < N; i++) data_in[32*i +: 32] = din[i];
  end

  ss_display_arbiter #(
    .N           (N),
    .HOLD_CYCLES (HOLD),
    .LZ_BLANK    (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .data_in     (data_in),
    .dp_in       (dp_in),
    .grant       (grant),
    .owner_valid (owner_valid),
    .data_BCD    (data_bcd),
    .DP          (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int rr_m(input int first, input logic [N-1:0] r);
    for (int k = 0; k < N; k++) begin
      if (r[(first + k) % N]) return (first + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [31:0] blank_m(input logic [31:0] w);
    logic [31:0] r;
    int d;
    r = w;
    d = 7;
    while (d > 0 && w[4*d +: 4] == 4'h0) begin
      r[4*d +: 4] = 4'hF;
      d--;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_held  = 0;
  endtask

  task automatic give_to(input int w);
    m_owner = w;
    m_last  = w;
    m_held  = 1;
  endtask

  task automatic model_step();
    logic [N-1:0] others;
    if (rst) begin
      model_reset();
    end else if (m_owner < 0) begin
      if (req != '0) give_to(rr_m(m_last + 1, req));
    end else begin
      others          = req;
      others[m_owner] = 1'b0;
      if (!req[m_owner]) begin
        if (others != '0) give_to(rr_m(m_owner + 1, others));
        else              m_owner = -1;
      end else if (m_held >= HOLD && others != '0) begin
        give_to(rr_m(m_owner + 1, others));
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [N-1:0] eg;
    logic [31:0]  ed;
    logic         ep;
    eg = '0;
    ed = 32'hFFFF_FFFF;
    ep = 1'b0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      ed          = blank_m(din[m_owner]);
      ep          = dp_in[m_owner];
    end
    check_eq({tag, "_grant"}, 32'(grant), 32'(eg));
    check_eq({tag, "_valid"}, 32'(owner_valid), 32'(m_owner >= 0));
    check_eq({tag, "_data"}, data_bcd, ed);
    check_eq({tag, "_dp"}, 32'(dp), 32'(ep));
    check_eq({tag, "_onehot"}, 32'($countones(grant) <= 1), 32'd1);
  endtask

  task automatic step_check(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_eq("rst_grant", 32'(grant), 32'd0);
    check_eq("rst_valid", 32'(owner_valid), 32'd0);
    check_eq("rst_data", data_bcd, 32'hFFFF_FFFF);
    check_eq("rst_dp", 32'(dp), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    int r;
    for (int d = 0; d < 8; d++) begin
      r = $urandom_range(0, 3);
      if (r < 2)       w[4*d +: 4] = 4'h0;
      else if (r == 2) w[4*d +: 4] = 4'($urandom_range(1, 9));
      else             w[4*d +: 4] = 4'($urandom_range(10, 15));
    end
    return w;
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    req      = '0;
    dp_in    = '0;
    din[0]   = 32'h0000_0120;
    din[1]   = 32'h0012_3456;
    din[2]   = 32'h0000_0789;
    model_reset();
    #2;
    do_reset();

    for (int i = 0; i < 3; i++) step_check("idle");

    req   = 3'b001;
    dp_in = 3'b001;
    step_check("first");
    check_eq("first_grant_abs", 32'(grant), 32'h1);
    check_eq("first_data_abs", data_bcd, 32'hFFFF_F120);

    do_reset();
    req = 3'b011;
    for (int k = 0; k < 9; k++) begin
      step_check("rr");
      check_eq("rr_seq", 32'(grant), (k < 4) ? 32'h1 : ((k < 8) ? 32'h2 : 32'h1));
    end

    do_reset();
    req = 3'b010;
    step_check("ho_a");
    step_check("ho_b");
    req = 3'b100;
    step_check("handover");
    check_eq("handover_grant_abs", 32'(grant), 32'h4);
    check_eq("handover_valid_abs", 32'(owner_valid), 32'h1);
    step_check("ho_c");

    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_eq("midrst_grant", 32'(grant), 32'd0);
    check_eq("midrst_data", data_bcd, 32'hFFFF_FFFF);
    check_eq("midrst_valid", 32'(owner_valid), 32'd0);
    #2;
    rst = 1'b0;
    req = 3'b111;
    step_check("after_rst");
    check_eq("after_rst_grant_abs", 32'(grant), 32'h1);

    req    = 3'b001;
    din[0] = 32'h0000_0000;
    step_check("zero");
    check_eq("zero_abs", data_bcd, 32'hFFFF_FFF0);
    din[0] = 32'hA000_0005;
    step_check("sym");
    check_eq("sym_abs", data_bcd, 32'hA000_0005);

    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0) req = N'($urandom_range(0, 7));
      for (int i = 0; i < N; i++) din[i] = rand_word();
      dp_in = N'($urandom_range(0, 7));
      step_check("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
